banner_animator: RTL and testbench

Animated ASCII-art banner renderer for the VGA title screen. Holds a HEIGHT×WIDTH character grid and lights a SCALE×SCALE block for every non-space, non-NUL cell. Adds frame-synchronised typewriter reveal, marquee scroll and blink modes, plus registered pixel outputs. Sits between the VGA timing generator (pixel_x/pixel_y, frame_tick) and the title-screen colour mux.

---
 rtl/banner_animator.sv | 179 +++++++++++++++++
 tb/tb_banner_animator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/banner_animator.sv
// rtl/banner_animator.sv - animated ASCII-art banner renderer for the VGA title screen
// Reveal/scroll/blink state advances on frame_tick; the pixel path is one registered stage.
module banner_animator #(
  parameter int                           WIDTH        = 80,
  parameter int                           HEIGHT       = 8,
  parameter int                           SCALE        = 4,
  parameter int                           STEP_FRAMES  = 2,
  parameter int                           BLINK_FRAMES = 30,
  parameter logic [2:0]                   COLOR        = 3'b111,
  // Row 0 is the most significant word; within a word the MSB byte is column 0.
  parameter logic [HEIGHT*8*WIDTH-1:0]    ART_DATA     = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [9:0] origin_x,
  input  logic [9:0] origin_y,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  output logic       banner_r,
  output logic       banner_g,
  output logic       banner_b,
  output logic       busy,
  output logic       done
);

  localparam int SHIFT = (SCALE == 8) ? 3 : (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam int FMAX  = (STEP_FRAMES > BLINK_FRAMES) ? STEP_FRAMES : BLINK_FRAMES;
  localparam int FCW   = (FMAX > 1) ? $clog2(FMAX) : 1;

  localparam logic [11:0]    XEXT     = 12'(WIDTH * SCALE);
  localparam logic [11:0]    YEXT     = 12'(HEIGHT * SCALE);
  localparam logic [10:0]    W11      = 11'(WIDTH);
  localparam logic [9:0]     WM1      = 10'(WIDTH - 1);
  localparam logic [FCW-1:0] STEP_M1  = FCW'(STEP_FRAMES - 1);
  localparam logic [FCW-1:0] BLINK_M1 = FCW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REVEAL, S_SHOW} state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [9:0]     reveal_cols_q, reveal_cols_d;
  logic [9:0]     scroll_q, scroll_d;
  logic           blink_vis_q, blink_vis_d;
  logic           done_d, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mode_q        <= 2'b00;
      frame_cnt_q   <= '0;
      reveal_cols_q <= '0;
      scroll_q      <= '0;
      blink_vis_q   <= 1'b1;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      frame_cnt_q   <= frame_cnt_d;
      reveal_cols_q <= reveal_cols_d;
      scroll_q      <= scroll_d;
      blink_vis_q   <= blink_vis_d;
      done          <= done_d;
      busy          <= busy_d;
    end
  end

  // stop beats start; a tick coincident with start is swallowed by the restart.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    frame_cnt_d   = frame_cnt_q;
    reveal_cols_d = reveal_cols_q;
    scroll_d      = scroll_q;
    blink_vis_d   = blink_vis_q;
    done_d        = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      mode_d        = mode;
      frame_cnt_d   = '0;
      reveal_cols_d = '0;
      scroll_d      = '0;
      blink_vis_d   = 1'b1;
      state_d       = (mode == 2'b01) ? S_REVEAL : S_SHOW;
    end else if (frame_tick) begin
      case (state_q)
        S_REVEAL: begin
          if (frame_cnt_q == STEP_M1) begin
            frame_cnt_d   = '0;
            reveal_cols_d = reveal_cols_q + 10'd1;
            if (reveal_cols_q == WM1) begin
              state_d = S_SHOW;
              done_d  = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (mode_q == 2'b10) begin
            if (frame_cnt_q == STEP_M1) begin
              frame_cnt_d = '0;
              scroll_d    = (scroll_q == WM1) ? 10'd0 : scroll_q + 10'd1;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end else if (mode_q == 2'b11) begin
            if (frame_cnt_q == BLINK_M1) begin
              frame_cnt_d = '0;
              blink_vis_d = ~blink_vis_q;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    // busy stays up through the done cycle
    busy_d = (state_d == S_REVEAL) || done_d;
  end

  logic [11:0]        px12, py12, ox12, oy12;
  logic               in_box;
  logic [9:0]         dx, dy, sx, sy;
  logic [10:0]        col;
  logic [8*WIDTH-1:0] row_word;
  logic [7:0]         ch;
  logic               lit;

  // Bounds are widened so an origin near 1023 clips instead of wrapping to low x/y.
  always_comb begin
    px12   = {2'b00, pixel_x};
    py12   = {2'b00, pixel_y};
    ox12   = {2'b00, origin_x};
    oy12   = {2'b00, origin_y};
    in_box = (px12 >= ox12) && (px12 < ox12 + XEXT) &&
             (py12 >= oy12) && (py12 < oy12 + YEXT);
    dx     = pixel_x - origin_x;
    dy     = pixel_y - origin_y;
    sx     = dx >> SHIFT;
    sy     = dy >> SHIFT;
    col    = {1'b0, sx};
    if (mode_q == 2'b10) begin
      col = {1'b0, sx} + {1'b0, scroll_q};
      if (col >= W11) col = col - W11;
    end
    row_word = '0;
    for (int r = 0; r < HEIGHT; r++) begin
      if (sy == 10'(r)) row_word = ART_DATA[(HEIGHT-1-r)*8*WIDTH +: 8*WIDTH];
    end
    ch = 8'h00;
    for (int c = 0; c < WIDTH; c++) begin
      if (col == 11'(c)) ch = row_word[(WIDTH-1-c)*8 +: 8];
    end
    lit = in_box && (ch != 8'h20) && (ch != 8'h00) && (state_q != S_IDLE) &&
          !((state_q == S_REVEAL) && (sx >= reveal_cols_q)) &&
          !((mode_q == 2'b11) && !blink_vis_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      banner_r <= 1'b0;
      banner_g <= 1'b0;
      banner_b <= 1'b0;
    end else begin
      banner_r <= lit & COLOR[2];
      banner_g <= lit & COLOR[1];
      banner_b <= lit & COLOR[0];
    end
  end

endmodule

// File: tb/tb_banner_animator.sv
// tb/tb_banner_animator.sv - self-checking bench for banner_animator
// Reference model tracks ticks since start and derives reveal/scroll/blink arithmetically.
module tb_banner_animator;
  localparam int         W     = 8;
  localparam int         H     = 2;
  localparam int         S     = 2;
  localparam int         STEP  = 2;
  localparam int         BLINK = 3;
  localparam logic [2:0] COL   = 3'b110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] pixel_x = '0, pixel_y = '0, origin_x = '0, origin_y = '0;
  logic       frame_tick = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       banner_r, banner_g, banner_b, busy, done;

  always #5 clk = ~clk;

  banner_animator #(
    .WIDTH(W), .HEIGHT(H), .SCALE(S), .STEP_FRAMES(STEP), .BLINK_FRAMES(BLINK),
    .COLOR(COL), .ART_DATA({"AB  CD##", "        "})
  ) dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .origin_x(origin_x), .origin_y(origin_y), .frame_tick(frame_tick),
    .start(start), .stop(stop), .mode(mode),
    .banner_r(banner_r), .banner_g(banner_g), .banner_b(banner_b),
    .busy(busy), .done(done)
  );

  int    n_pass = 0, n_total = 0;
  int    m_state = 0, m_mode = 0, m_ticks = 0;
  string art [2];
  logic [2:0] exp_rgb = '0;
  logic       exp_done = 1'b0, exp_busy = 1'b0;

  function automatic logic model_lit(int px, int py, int ox, int oy);
    int sx, sy, c;
    byte ch;
    if (m_state == 0) return 1'b0;
    if (px < ox || px >= ox + W*S || py < oy || py >= oy + H*S) return 1'b0;
    sx = (px - ox) / S;
    sy = (py - oy) / S;
    if (m_state == 1 && sx >= m_ticks / STEP) return 1'b0;
    if (m_mode == 3 && ((m_ticks / BLINK) % 2) == 1) return 1'b0;
    c  = (m_mode == 2) ? (sx + (m_ticks / STEP) % W) % W : sx;
    ch = art[sy].getc(c);
    return (ch != 8'h20) && (ch != 8'h00);
  endfunction

  task automatic cycle();
    logic lit, d;
    lit = model_lit(int'(pixel_x), int'(pixel_y), int'(origin_x), int'(origin_y));
    d   = 1'b0;
    if (rst) begin
      m_state = 0; m_mode = 0; m_ticks = 0;
    end else if (stop) begin
      m_state = 0;
    end else if (start) begin
      m_mode = int'(mode); m_ticks = 0; m_state = (mode == 2'b01) ? 1 : 2;
    end else if (frame_tick) begin
      if (m_state == 1) begin
        m_ticks++;
        if (m_ticks == W*STEP) begin m_state = 2; d = 1'b1; end
      end else if (m_state == 2 && (m_mode == 2 || m_mode == 3)) begin
        m_ticks++;
      end
    end
    @(posedge clk); #1;
    if (rst) begin
      exp_rgb = '0; exp_done = 1'b0; exp_busy = 1'b0;
    end else begin
      exp_rgb  = lit ? COL : 3'b000;
      exp_done = d;
      exp_busy = (m_state == 1) || d;
    end
    start = 1'b0; stop = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic set_px(int x, int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
  endtask

  task automatic test_reset();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b000) $display("FAIL reset_rgb got %b want 000", {banner_r, banner_g, banner_b}); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_static();
    int xs [4] = '{100, 104, 116, 100};
    int ys [4] = '{50, 50, 50, 52};
    logic [2:0] want [4] = '{3'b110, 3'b000, 3'b000, 3'b000};
    origin_x = 10'd100; origin_y = 10'd50;
    mode = 2'b00; start = 1'b1; cycle();
    for (int i = 0; i < 4; i++) begin
      set_px(xs[i], ys[i]); cycle();
      n_total++; if ({banner_r, banner_g, banner_b} !== want[i]) $display("FAIL static_pt%0d got %b want %b", i, {banner_r, banner_g, banner_b}, want[i]); else n_pass++;
      n_total++; if ({banner_r, banner_g, banner_b} !== exp_rgb) $display("FAIL static_model%0d got %b want %b", i, {banner_r, banner_g, banner_b}, exp_rgb); else n_pass++;
    end
  endtask

  task automatic test_typewriter();
    int dones = 0;
    mode = 2'b01; start = 1'b1; cycle();
    n_total++; if (busy !== 1'b1) $display("FAIL tw_busy_start got %b want 1", busy); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      frame_tick = 1'b1; set_px(100 + $urandom_range(0, 15), 50 + $urandom_range(0, 3)); cycle();
      n_total++; if ({banner_r, banner_g, banner_b} !== exp_rgb) $display("FAIL tw_pix got %b want %b", {banner_r, banner_g, banner_b}, exp_rgb); else n_pass++;
    end
    set_px(102, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b110) $display("FAIL tw_col1_lit got %b want 110", {banner_r, banner_g, banner_b}); else n_pass++;
    set_px(108, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b000) $display("FAIL tw_col4_dark got %b want 000", {banner_r, banner_g, banner_b}); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      frame_tick = 1'b1; cycle();
      if (done === 1'b1) dones++;
      n_total++; if (done !== exp_done) $display("FAIL tw_done got %b want %b", done, exp_done); else n_pass++;
      n_total++; if (busy !== exp_busy) $display("FAIL tw_busy got %b want %b", busy, exp_busy); else n_pass++;
    end
    cycle();
    n_total++; if (dones !== 1) $display("FAIL tw_done_count got %0d want 1", dones); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL tw_busy_after got %b want 0", busy); else n_pass++;
    for (int x = 100; x < 116; x++) begin
      set_px(x, 50); cycle();
      n_total++; if ({banner_r, banner_g, banner_b} !== exp_rgb) $display("FAIL tw_full x=%0d got %b want %b", x, {banner_r, banner_g, banner_b}, exp_rgb); else n_pass++;
    end
  endtask

  task automatic test_marquee();
    mode = 2'b10; start = 1'b1; cycle();
    frame_tick = 1'b1; cycle(); frame_tick = 1'b1; cycle();
    set_px(100, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b110) $display("FAIL mq_B_lit got %b want 110", {banner_r, banner_g, banner_b}); else n_pass++;
    set_px(102, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b000) $display("FAIL mq_space got %b want 000", {banner_r, banner_g, banner_b}); else n_pass++;
    for (int i = 0; i < 14; i++) begin
      frame_tick = 1'b1; set_px(98 + $urandom_range(0, 20), 49 + $urandom_range(0, 6)); cycle();
      n_total++; if ({banner_r, banner_g, banner_b} !== exp_rgb) $display("FAIL mq_pix got %b want %b", {banner_r, banner_g, banner_b}, exp_rgb); else n_pass++;
    end
    set_px(102, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b110) $display("FAIL mq_wrap got %b want 110", {banner_r, banner_g, banner_b}); else n_pass++;
  endtask

  task automatic test_blink();
    logic [2:0] want;
    mode = 2'b11; start = 1'b1; set_px(100, 50); cycle();
    for (int k = 1; k <= 6; k++) begin
      frame_tick = 1'b1; cycle();
      cycle();
      want = (k < 3 || k >= 6) ? 3'b110 : 3'b000;
      n_total++; if ({banner_r, banner_g, banner_b} !== want) $display("FAIL blink_tick%0d got %b want %b", k, {banner_r, banner_g, banner_b}, want); else n_pass++;
    end
  endtask

  task automatic test_precedence();
    int dones = 0;
    mode = 2'b00; start = 1'b1; stop = 1'b1; set_px(100, 50); cycle();
    cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b000) $display("FAIL prec_stop got %b want 000", {banner_r, banner_g, banner_b}); else n_pass++;
    mode = 2'b10; start = 1'b1; frame_tick = 1'b1; cycle();
    frame_tick = 1'b1; cycle();
    set_px(102, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b110) $display("FAIL prec_tick_start got %b want 110", {banner_r, banner_g, banner_b}); else n_pass++;
    mode = 2'b01; start = 1'b1; cycle();
    for (int i = 0; i < 5; i++) begin frame_tick = 1'b1; cycle(); end
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      frame_tick = 1'b1; set_px(100, 50); cycle();
      if (done === 1'b1) dones++;
    end
    n_total++; if (dones !== 0) $display("FAIL prec_rst_done got %0d want 0", dones); else n_pass++;
    n_total++; if ({banner_r, banner_g, banner_b, busy} !== 4'b0000) $display("FAIL prec_rst_idle got %b want 0000", {banner_r, banner_g, banner_b, busy}); else n_pass++;
  endtask

  task automatic test_clipping();
    origin_x = 10'd1000; origin_y = 10'd50;
    mode = 2'b00; start = 1'b1; cycle();
    set_px(1023, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b000) $display("FAIL clip_1023 got %b want 000", {banner_r, banner_g, banner_b}); else n_pass++;
    set_px(0, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b000) $display("FAIL clip_0 got %b want 000", {banner_r, banner_g, banner_b}); else n_pass++;
    set_px(1000, 50); cycle();
    n_total++; if ({banner_r, banner_g, banner_b} !== 3'b110) $display("FAIL clip_origin got %b want 110", {banner_r, banner_g, banner_b}); else n_pass++;
  endtask

  task automatic test_random();
    int x, y;
    origin_x = 10'd100; origin_y = 10'd50;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) begin start = 1'b1; mode = 2'($urandom_range(0, 3)); end
      if ($urandom_range(0, 99) == 0) stop = 1'b1;
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) begin
        origin_x = 10'($urandom_range(0, 1023)); origin_y = 10'($urandom_range(0, 1023));
      end
      x = int'(origin_x) + int'($urandom_range(0, 22)) - 3;
      y = int'(origin_y) + int'($urandom_range(0, 8)) - 2;
      if (x < 0) x = 0; if (x > 1023) x = 1023;
      if (y < 0) y = 0; if (y > 1023) y = 1023;
      set_px(x, y); cycle();
      n_total++; if ({banner_r, banner_g, banner_b} !== exp_rgb) $display("FAIL rnd_rgb i=%0d got %b want %b", i, {banner_r, banner_g, banner_b}, exp_rgb); else n_pass++;
      n_total++; if (done !== exp_done) $display("FAIL rnd_done i=%0d got %b want %b", i, done, exp_done); else n_pass++;
      n_total++; if (busy !== exp_busy) $display("FAIL rnd_busy i=%0d got %b want %b", i, busy, exp_busy); else n_pass++;
    end
  endtask

  initial begin
    art[0] = "AB  CD##";
    art[1] = "        ";
    test_reset();
    test_static();
    test_typewriter();
    test_marquee();
    test_blink();
    test_precedence();
    test_clipping();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
